// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI frame width, mode constants and FSM state encoding
package spi_pkg;
  localparam int SPI_DW = 8;
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;
  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: N-stage synchroniser with rise/fall pulses on the synchronised level
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES:0] s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= {(STAGES+1){RST_VAL}};
    else s <= {s[STAGES-1:0], d};
  assign rise = s[STAGES-1] & ~s[STAGES];
  assign fall = ~s[STAGES-1] & s[STAGES];
endmodule

// File: rtl/spi_slave_duplex.sv
// spi_slave_duplex: oversampled full-duplex SPI mode-0 slave with one-entry tx buffer
module spi_slave_duplex import spi_pkg::*; #(
  parameter int DATA_WIDTH  = SPI_DW,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  overrun
);
  localparam int CW = $clog2(DATA_WIDTH);
  state_t state, state_nxt;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [DATA_WIDTH-1:0] tx_shift, rx_shift, tx_buf;
  logic [CW-1:0] bit_cnt;
  logic buf_full, reload_pend, starved, hs, take, last_bit, start, active;
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CPOL)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .d(cs_n), .rise(cs_rise), .fall(cs_fall));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mosi_sync <= '0;
    else mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == ST_IDLE) ? (cs_fall ? ST_SHIFT : ST_IDLE) : (cs_rise ? ST_IDLE : ST_SHIFT);
  always_comb begin
    busy    = state == ST_SHIFT;
    miso_oe = busy;
    miso    = busy & tx_shift[DATA_WIDTH-1];
  end
  assign tx_ready = ~buf_full;
  assign hs       = tx_valid & ~buf_full;
  assign last_bit = bit_cnt == CW'(DATA_WIDTH-1);
  assign start    = (state == ST_IDLE) & cs_fall;
  assign active   = (state == ST_SHIFT) & ~cs_rise;
  assign take     = buf_full & (start | (active & ~sclk_rise & sclk_fall & reload_pend));
  // An empty reload between frames only counts as overrun once the next frame is clocked,
  // so the idle sclk fall that ends a single frame does not flag it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_shift    <= '0;
      rx_shift    <= '0;
      tx_buf      <= '0;
      rx_data     <= '0;
      bit_cnt     <= '0;
      buf_full    <= 1'b0;
      reload_pend <= 1'b0;
      starved     <= 1'b0;
      rx_valid    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      buf_full <= hs | (buf_full & ~take);
      if (hs) tx_buf <= tx_data;
      if (hs) overrun <= 1'b0;
      if (start) begin
        tx_shift    <= buf_full ? tx_buf : '0;
        bit_cnt     <= '0;
        reload_pend <= 1'b0;
        starved     <= 1'b0;
        if (!buf_full) overrun <= 1'b1;
      end else if (active && sclk_rise) begin
        rx_shift    <= {rx_shift[DATA_WIDTH-2:0], mosi_sync[SYNC_STAGES-1]};
        bit_cnt     <= last_bit ? '0 : bit_cnt + 1'b1;
        reload_pend <= last_bit;
        starved     <= 1'b0;
        if (starved) overrun <= 1'b1;
        if (last_bit) begin
          rx_data  <= {rx_shift[DATA_WIDTH-2:0], mosi_sync[SYNC_STAGES-1]};
          rx_valid <= 1'b1;
        end
      end else if (active && sclk_fall) begin
        tx_shift    <= reload_pend ? (buf_full ? tx_buf : '0) : tx_shift << 1;
        starved     <= reload_pend & ~buf_full;
        reload_pend <= 1'b0;
      end
    end
endmodule

// File: tb/tb_spi_slave_duplex.sv
// tb_spi_slave_duplex: directed mode-0 master model exercising the SPI slave
module tb_spi_slave_duplex;
  logic clk = 0, rst_n = 0, sclk = 0, cs_n = 1, mosi = 0, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic miso, miso_oe, tx_ready, rx_valid, busy, overrun;
  logic [7:0] rx_data;
  int tests = 0, fails = 0, rv_cnt = 0;
  logic [7:0] rv_data = 0;
  time rv_time = 0, last_rise = 0;

  spi_slave_duplex dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .overrun(overrun));

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rx_valid === 1'b1) begin
      rv_cnt++;
      rv_data = rx_data;
      rv_time = $time;
    end

  task automatic push(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    tx_data = b;
    tx_valid = 1;
    while (tx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL push_timeout: tx_ready=%b want 1 for byte %h", tx_ready, b);
    end
    @(posedge clk);
    #1 tx_valid = 0;
    @(negedge clk);
    tests++;
    if (tx_ready !== 1'b0) begin
      fails++;
      $display("FAIL tx_ready_full: got %b want 0 after byte %h", tx_ready, b);
    end
  endtask

  task automatic sel();
    @(negedge clk);
    cs_n = 0;
    #50;
  endtask

  task automatic desel();
    #50 cs_n = 1;
    #100;
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = mo[i];
      #50 sclk = 1;
      last_rise = $time;
      mi[i] = miso;
      #50 sclk = 0;
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({miso, miso_oe, tx_ready, rx_data, rx_valid, busy, overrun} !== {3'b001, 8'h00, 3'b000}) begin
      fails++;
      $display("FAIL reset_values: got %b want %b",
               {miso, miso_oe, tx_ready, rx_data, rx_valid, busy, overrun}, {3'b001, 8'h00, 3'b000});
    end
    rst_n = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] mi;
    int rv0;
    push(8'hA5);
    rv0 = rv_cnt;
    sel();
    chk8("busy_oe_selected", {6'b0, busy, miso_oe}, 8'h03);
    xfer(8'h3C, 8, mi);
    chk8("rx_latency_ns", 8'(rv_time - last_rise), 8'd30);
    desel();
    chk8("basic_rv_count", 8'(rv_cnt - rv0), 8'd1);
    chk8("basic_rx_data", rx_data, 8'h3C);
    chk8("basic_miso", mi, 8'hA5);
    chk8("basic_overrun", {7'b0, overrun}, 8'h00);
    chk8("basic_idle", {6'b0, busy, miso_oe}, 8'h00);
  endtask

  task automatic test_overrun();
    logic [7:0] mi;
    sel();
    xfer(8'hF0, 8, mi);
    desel();
    chk8("ovr_miso", mi, 8'h00);
    chk8("ovr_flag_set", {7'b0, overrun}, 8'h01);
    chk8("ovr_rx_data", rx_data, 8'hF0);
    push(8'h11);
    chk8("ovr_flag_cleared", {7'b0, overrun}, 8'h00);
    sel();
    xfer(8'h00, 8, mi);
    desel();
    chk8("ovr_drain_miso", mi, 8'h11);
    chk8("ovr_drain_flag", {7'b0, overrun}, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] m1, m2;
    int rv0;
    push(8'h81);
    rv0 = rv_cnt;
    @(negedge clk);
    cs_n = 0;
    repeat (5) @(negedge clk);
    push(8'h7E);
    xfer(8'h55, 8, m1);
    chk8("b2b_first_rx", rv_data, 8'h55);
    xfer(8'hAA, 8, m2);
    desel();
    chk8("b2b_miso1", m1, 8'h81);
    chk8("b2b_miso2", m2, 8'h7E);
    chk8("b2b_rv_count", 8'(rv_cnt - rv0), 8'd2);
    chk8("b2b_rx_data", rx_data, 8'hAA);
    chk8("b2b_overrun", {7'b0, overrun}, 8'h00);
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    int rv0;
    rv0 = rv_cnt;
    sel();
    xfer(8'hFF, 5, mi);
    desel();
    chk8("abort_no_rv", 8'(rv_cnt - rv0), 8'd0);
    chk8("abort_rx_kept", rx_data, 8'hAA);
    chk8("abort_idle", {6'b0, busy, miso_oe}, 8'h00);
    sel();
    xfer(8'h12, 8, mi);
    desel();
    chk8("abort_next_rx", rx_data, 8'h12);
    chk8("abort_next_rv", 8'(rv_cnt - rv0), 8'd1);
  endtask

  task automatic test_async_reset();
    logic [7:0] mi;
    push(8'h99);
    sel();
    xfer(8'hFF, 4, mi);
    #3 rst_n = 0;
    #1;
    tests++;
    if ({miso, miso_oe, tx_ready, rx_data, rx_valid, busy, overrun} !== {3'b001, 8'h00, 3'b000}) begin
      fails++;
      $display("FAIL async_reset: got %b want %b",
               {miso, miso_oe, tx_ready, rx_data, rx_valid, busy, overrun}, {3'b001, 8'h00, 3'b000});
    end
    cs_n = 1;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    push(8'hC3);
    sel();
    xfer(8'h5A, 8, mi);
    desel();
    chk8("post_reset_miso", mi, 8'hC3);
    chk8("post_reset_rx", rx_data, 8'h5A);
    chk8("post_reset_overrun", {7'b0, overrun}, 8'h00);
  endtask

  task automatic test_random();
    logic [7:0] bt, br, mi;
    int rv0;
    for (int k = 0; k < 20; k++) begin
      bt = 8'($urandom);
      br = 8'($urandom);
      push(bt);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      rv0 = rv_cnt;
      sel();
      xfer(br, 8, mi);
      desel();
      chk8("rand_miso", mi, bt);
      chk8("rand_rx", rv_data, br);
      chk8("rand_rv_count", 8'(rv_cnt - rv0), 8'd1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
